// File: rtl/text_layer.sv
// rtl/text_layer.sv - scaled single-line text overlay with blink and typewriter reveal
module font_rom (
    input  logic [10:0] addr,
    output logic [7:0]  data
);
    // Sparse glyph set: space and unlisted codes are blank, 0x7F is a solid block
    always_comb begin
        data = 8'h00;
        case (addr[10:4])
            7'h41: begin
                case (addr[3:0])
                    4'd2:                   data = 8'h10;
                    4'd3:                   data = 8'h38;
                    4'd4:                   data = 8'h6C;
                    4'd5, 4'd6:             data = 8'hC6;
                    4'd7:                   data = 8'hFE;
                    4'd8, 4'd9, 4'd10, 4'd11: data = 8'hC6;
                    default:                data = 8'h00;
                endcase
            end
            7'h50: begin
                case (addr[3:0])
                    4'd2:                   data = 8'hFC;
                    4'd3, 4'd4, 4'd5:       data = 8'h66;
                    4'd6:                   data = 8'h7C;
                    4'd7, 4'd8, 4'd9, 4'd10: data = 8'h60;
                    4'd11:                  data = 8'hF0;
                    default:                data = 8'h00;
                endcase
            end
            7'h7F:   data = 8'hFF;
            default: data = 8'h00;
        endcase
    end
endmodule

module text_layer #(
    parameter int N_CHARS       = 22,
    parameter int SCALE         = 3,
    parameter int X0            = 56,
    parameter int Y0            = 400,
    parameter int BLINK_FRAMES  = 30,
    parameter int REVEAL_FRAMES = 4,
    localparam int AW = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_char,
    input  logic [1:0]    mode,
    input  logic          restart,
    output logic          text_on,
    output logic          busy
);
    localparam int CW = $clog2(N_CHARS + 1);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int RW = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [11:0] X_LO = 12'(X0);
    localparam logic [11:0] X_HI = 12'(X0 + 8 * SCALE * N_CHARS);
    localparam logic [11:0] Y_LO = 12'(Y0);
    localparam logic [11:0] Y_HI = 12'(Y0 + 16 * SCALE);
    localparam logic [AW:0]   N_LIM     = (AW + 1)'(N_CHARS);
    localparam logic [CW-1:0] N_FULL    = CW'(N_CHARS);
    localparam logic [BW-1:0] BLINK_END = BW'(BLINK_FRAMES - 1);
    localparam logic [RW-1:0] SUB_LAST  = RW'(REVEAL_FRAMES - 1);

    typedef enum logic {IDLE, REVEAL} state_t;

    // Power-up contents are spaces; reset deliberately leaves the buffer alone
    logic [7:0] char_buf [N_CHARS] = '{default: 8'h20};

    logic          in_box, in_box_q, at_origin, origin_q, frame_tick, visible;
    logic [9:0]    dx, dy, c_full, fx_full, fy_full;
    logic [AW-1:0] rd_idx;
    logic [CW-1:0] c_q;
    logic [2:0]    fx_q;
    logic [3:0]    fy_q;
    logic [6:0]    char_q;
    logic [7:0]    font_data;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    state_t        state, state_nx;
    logic [CW-1:0] reveal_cnt, cnt_nx;
    logic [RW-1:0] sub_cnt, sub_nx;
    logic          unused_bits;

    assign in_box = ({2'b00, DrawX} >= X_LO) && ({2'b00, DrawX} < X_HI) &&
                    ({2'b00, DrawY} >= Y_LO) && ({2'b00, DrawY} < Y_HI);
    assign dx      = DrawX - 10'(X0);
    assign dy      = DrawY - 10'(Y0);
    assign c_full  = dx / 10'(8 * SCALE);
    assign fx_full = dx / 10'(SCALE);
    assign fy_full = dy / 10'(SCALE);
    assign rd_idx  = in_box ? c_full[AW-1:0] : '0;
    assign unused_bits = ^{c_full, fx_full[9:3], fy_full[9:4]};

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < N_LIM)) begin
            char_buf[wr_addr] <= wr_char;
        end
    end

    // Stage 1: geometry and synchronous (read-before-write) buffer read
    always_ff @(posedge clk) begin
        c_q    <= c_full[CW-1:0];
        fx_q   <= fx_full[2:0];
        fy_q   <= fy_full[3:0];
        char_q <= char_buf[rd_idx][6:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_box_q <= 1'b0;
            origin_q <= 1'b0;
        end else begin
            in_box_q <= in_box;
            origin_q <= at_origin;
        end
    end

    assign at_origin  = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign frame_tick = at_origin & ~origin_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_END) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            reveal_cnt <= N_FULL;
            sub_cnt    <= '0;
        end else begin
            state      <= state_nx;
            reveal_cnt <= cnt_nx;
            sub_cnt    <= sub_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = reveal_cnt;
        sub_nx   = sub_cnt;
        case (state)
            IDLE: begin
                cnt_nx = N_FULL;
                sub_nx = '0;
                if (restart && (mode == 2'b10)) begin
                    state_nx = REVEAL;
                    cnt_nx   = '0;
                end
            end
            REVEAL: begin
                if (mode != 2'b10) begin
                    state_nx = IDLE;
                    cnt_nx   = N_FULL;
                    sub_nx   = '0;
                end else if (restart) begin
                    cnt_nx = '0;
                    sub_nx = '0;
                end else if (frame_tick) begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_nx = '0;
                        cnt_nx = reveal_cnt + 1'b1;
                        if (cnt_nx == N_FULL) begin
                            state_nx = IDLE;
                        end
                    end else begin
                        sub_nx = sub_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == REVEAL);
        visible = 1'b1;
        case (mode)
            2'b01:   visible = ~blink_phase;
            2'b10:   visible = (c_q < reveal_cnt);
            default: visible = 1'b1;
        endcase
    end

    font_rom u_font (
        .addr ({char_q, fy_q}),
        .data (font_data)
    );

    // Stage 2: glyph row lookup and pixel select
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            text_on <= 1'b0;
        end else begin
            text_on <= in_box_q & visible & font_data[3'd7 - fx_q];
        end
    end
endmodule

// File: tb/tb_text_layer.sv
// tb/tb_text_layer.sv - self-checking bench for text_layer against a pixel-level model
module tb_text_layer;
    localparam int NA = 22, NB = 4, SC = 3, XS = 56, YS = 400;
    localparam int BFA = 30, RFA = 4, BFB = 2, RFB = 1;
    localparam int FAR = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, wr_en_a, wr_en_b, restart;
    logic [9:0] draw_x, draw_y;
    logic [4:0] wr_addr_a;
    logic [1:0] wr_addr_b;
    logic [7:0] wr_char;
    logic [1:0] mode;
    logic       text_on_a, busy_a, text_on_b, busy_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] mbuf_a [NA];
    logic [7:0] mbuf_b [NB];
    int m_ticks, m_rt_a, m_rt_b;
    bit m_prev00, m_rev_a, m_rev_b;
    bit qa[$];
    bit qb[$];

    text_layer u_a (
        .clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_char(wr_char),
        .mode(mode), .restart(restart), .text_on(text_on_a), .busy(busy_a)
    );

    text_layer #(.N_CHARS(NB), .BLINK_FRAMES(BFB), .REVEAL_FRAMES(RFB)) u_b (
        .clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_char(wr_char),
        .mode(mode), .restart(restart), .text_on(text_on_b), .busy(busy_b)
    );

    function automatic logic [7:0] glyph(input logic [7:0] ch, input int fy);
        logic [7:0] row;
        row = 8'h00;
        case (ch[6:0])
            7'h41: begin
                if (fy == 2) row = 8'h10;
                else if (fy == 3) row = 8'h38;
                else if (fy == 4) row = 8'h6C;
                else if (fy == 7) row = 8'hFE;
                else if (fy >= 5 && fy <= 11) row = 8'hC6;
            end
            7'h50: begin
                if (fy == 2) row = 8'hFC;
                else if (fy >= 3 && fy <= 5) row = 8'h66;
                else if (fy == 6) row = 8'h7C;
                else if (fy >= 7 && fy <= 10) row = 8'h60;
                else if (fy == 11) row = 8'hF0;
            end
            7'h7F:   row = 8'hFF;
            default: row = 8'h00;
        endcase
        return row;
    endfunction

    function automatic int shown(input bit rev, input int rt, input int rf, input int n);
        if (!rev) return n;
        return (rt / rf < n) ? rt / rf : n;
    endfunction

    function automatic bit exp_pix(input bit inst_b, input int x, input int y);
        int n, bf, dx, c, fx, fy;
        bit vis;
        logic [7:0] row, ch;
        n  = inst_b ? NB : NA;
        bf = inst_b ? BFB : BFA;
        if (x < XS || x >= XS + 8 * SC * n || y < YS || y >= YS + 16 * SC) return 1'b0;
        dx = x - XS;
        c  = dx / (8 * SC);
        fx = (dx / SC) % 8;
        fy = (y - YS) / SC;
        ch = inst_b ? mbuf_b[c] : mbuf_a[c];
        case (mode)
            2'b01:   vis = ((m_ticks / bf) % 2) == 0;
            2'b10:   vis = c < (inst_b ? shown(m_rev_b, m_rt_b, RFB, NB) : shown(m_rev_a, m_rt_a, RFA, NA));
            default: vis = 1'b1;
        endcase
        row = glyph(ch, fy);
        return vis && row[7 - fx];
    endfunction

    // One clock with coordinate (x,y); expectations use post-edge control state, pre-edge buffer
    task automatic cycle(input int x, input int y);
        bit tick, e;
        draw_x = 10'(x);
        draw_y = 10'(y);
        if (!reset_n) begin
            qa.delete(); qb.delete();
            qa.push_back(1'b0); qb.push_back(1'b0);
            qa.push_back(1'b0); qb.push_back(1'b0);
            m_ticks = 0; m_prev00 = 1'b0;
            m_rev_a = 1'b0; m_rev_b = 1'b0; m_rt_a = 0; m_rt_b = 0;
        end else begin
            tick = (x == 0 && y == 0) && !m_prev00;
            m_prev00 = (x == 0 && y == 0);
            if (tick) m_ticks++;
            if (mode != 2'b10) begin
                m_rev_a = 1'b0; m_rev_b = 1'b0;
            end else if (restart) begin
                m_rev_a = 1'b1; m_rt_a = 0; m_rev_b = 1'b1; m_rt_b = 0;
            end else if (tick) begin
                if (m_rev_a) begin m_rt_a++; if (m_rt_a / RFA >= NA) m_rev_a = 1'b0; end
                if (m_rev_b) begin m_rt_b++; if (m_rt_b / RFB >= NB) m_rev_b = 1'b0; end
            end
            qa.push_back(exp_pix(1'b0, x, y));
            qb.push_back(exp_pix(1'b1, x, y));
        end
        if (wr_en_a && wr_addr_a < NA) mbuf_a[wr_addr_a] = wr_char;
        if (wr_en_b) mbuf_b[wr_addr_b] = wr_char;
        @(posedge clk);
        #1;
        if (qa.size() == 2) begin
            e = qa.pop_front();
            checks++;
            if (text_on_a !== e) begin
                errors++;
                $display("FAIL text_on_a t=%0t got %b expected %b", $time, text_on_a, e);
            end
        end
        if (qb.size() == 2) begin
            e = qb.pop_front();
            checks++;
            if (text_on_b !== e) begin
                errors++;
                $display("FAIL text_on_b t=%0t got %b expected %b", $time, text_on_b, e);
            end
        end
        checks++;
        if (busy_a !== m_rev_a) begin
            errors++;
            $display("FAIL busy_a t=%0t got %b expected %b", $time, busy_a, m_rev_a);
        end
        checks++;
        if (busy_b !== m_rev_b) begin
            errors++;
            $display("FAIL busy_b t=%0t got %b expected %b", $time, busy_b, m_rev_b);
        end
    endtask

    task automatic wr(input bit en_a, input int addr_a, input bit en_b, input int addr_b,
                      input logic [7:0] ch, input int x, input int y);
        wr_en_a = en_a; wr_addr_a = 5'(addr_a);
        wr_en_b = en_b; wr_addr_b = 2'(addr_b);
        wr_char = ch;
        cycle(x, y);
        wr_en_a = 1'b0; wr_en_b = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        cycle(FAR, FAR);
        mode = m;
    endtask

    task automatic pulse_restart(input int x, input int y);
        restart = 1'b1;
        cycle(x, y);
        restart = 1'b0;
    endtask

    task automatic frame_tick_pair();
        cycle(0, 0);
        cycle(FAR, FAR);
    endtask

    task automatic scan_b_row(input int y);
        for (int x = 56; x < 152; x += 3) cycle(x, y);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycle(FAR, FAR);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycle(FAR, FAR);
        cycle(FAR, FAR);
        checks++;
        if (text_on_a !== 1'b0 || text_on_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_text_on got %b%b expected 00", text_on_a, text_on_b);
        end
        reset_n = 1'b1;
        cycle(FAR, FAR);
    endtask

    task automatic test_glyph_p();
        wr(1'b1, 0, 1'b1, 0, 8'h50, FAR, FAR);
        for (int x = 50; x < 90; x++) cycle(x, 406);
        cycle(FAR, FAR);
        cycle(FAR, FAR);
    endtask

    task automatic test_read_before_write();
        for (int x = 56; x < 80; x++) begin
            if (x == 60) wr(1'b1, 0, 1'b1, 0, 8'h41, x, 406);
            else cycle(x, 406);
        end
        cycle(FAR, FAR);
    endtask

    task automatic test_edges();
        int px[10] = '{55, 56, 583, 584, 300, 300, 300, 300, 151, 152};
        int py[10] = '{420, 420, 420, 420, 399, 400, 447, 448, 420, 420};
        for (int i = 0; i < NA; i++) wr(1'b1, i, i < NB, i % NB, 8'h7F, FAR, FAR);
        for (int i = 0; i < 10; i++) cycle(px[i], py[i]);
        cycle(FAR, FAR);
    endtask

    task automatic test_random_pixels();
        logic [7:0] chars[5] = '{8'h20, 8'h41, 8'h50, 8'h7F, 8'h00};
        for (int i = 0; i < 400; i++) begin
            int x, y;
            if ($urandom_range(0, 9) == 0) begin
                x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
            end else begin
                x = $urandom_range(40, 620); y = $urandom_range(390, 460);
            end
            if ($urandom_range(0, 3) == 0) begin
                chars[4] = 8'($urandom);
                wr(1'b1, $urandom_range(0, 31), 1'b1, $urandom_range(0, 3),
                   chars[$urandom_range(0, 4)], x, y);
            end else begin
                cycle(x, y);
            end
        end
        cycle(FAR, FAR);
    endtask

    task automatic test_blink();
        do_reset();
        set_mode(2'b01);
        for (int i = 0; i < NB; i++) wr(1'b0, 0, 1'b1, i, 8'h7F, FAR, FAR);
        for (int f = 0; f < 6; f++) begin
            scan_b_row(420);
            frame_tick_pair();
        end
    endtask

    task automatic test_reveal();
        set_mode(2'b10);
        scan_b_row(420);
        pulse_restart(FAR, FAR);
        for (int f = 0; f < 8; f++) begin
            scan_b_row(420);
            if (f == 2) pulse_restart(FAR, FAR);
            frame_tick_pair();
        end
        scan_b_row(420);
    endtask

    task automatic test_reset_mid_reveal();
        pulse_restart(FAR, FAR);
        frame_tick_pair();
        frame_tick_pair();
        for (int x = 56; x < 100; x++) begin
            if (x == 70) reset_n = 1'b0;
            cycle(x, 420);
            reset_n = 1'b1;
        end
        scan_b_row(420);
        for (int x = 56; x < 584; x += 7) cycle(x, 430);
        cycle(FAR, FAR);
    endtask

    task automatic test_random_modes();
        for (int r = 0; r < 8; r++) begin
            set_mode(2'($urandom_range(0, 3)));
            for (int i = 0; i < 80; i++) begin
                int sel, x, y;
                sel = $urandom_range(0, 99);
                x = $urandom_range(40, 600);
                y = $urandom_range(395, 452);
                if (sel < 8) cycle(0, 0);
                else if (sel < 12) pulse_restart(x, y);
                else cycle(x, y);
            end
        end
        cycle(FAR, FAR);
    endtask

    initial begin
        for (int i = 0; i < NA; i++) mbuf_a[i] = 8'h20;
        for (int i = 0; i < NB; i++) mbuf_b[i] = 8'h20;
        reset_n = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0; restart = 1'b0;
        wr_addr_a = '0; wr_addr_b = '0; wr_char = '0; mode = 2'b00;
        draw_x = 10'(FAR); draw_y = 10'(FAR);
        m_ticks = 0; m_prev00 = 1'b0; m_rev_a = 1'b0; m_rev_b = 1'b0; m_rt_a = 0; m_rt_b = 0;

        test_reset();
        test_glyph_p();
        test_read_before_write();
        test_edges();
        test_random_pixels();
        test_blink();
        test_reveal();
        test_reset_mid_reveal();
        test_random_modes();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/text_layer.md
TEXT_LAYER -- requirements
Module: text_layer

Interface
REQ-001 SHALL have parameter N_CHARS, default 22, number of characters in the text line (1..64).
REQ-002 SHALL have parameter SCALE, default 3, integer pixel magnification (1..4).
REQ-003 SHALL have parameters X0, default 56, and Y0, default 400, giving the top-left screen pixel of the text box.
REQ-004 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period (>=1).
REQ-005 SHALL have parameter REVEAL_FRAMES, default 4, frames per typewriter character (>=1).
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, reset, synchronous, active-low.
REQ-008 SHALL have ports DrawX and DrawY, input, 10 each, current VGA pixel coordinate.
REQ-009 SHALL have ports wr_en (1), wr_addr (clog2(N_CHARS)) and wr_char (8), inputs, character-buffer write port.
REQ-010 SHALL have port mode, input, 2, with 00 static, 01 blink, 10 typewriter and 11 treated as 00.
REQ-011 SHALL have port restart, input, 1, a one-cycle pulse that starts a typewriter reveal.
REQ-012 SHALL have port text_on, output, 1, foreground pixel flag aligned to DrawX/DrawY delayed 2 cycles.
REQ-013 SHALL have port busy, output, 1, high while a reveal is in progress.

Function
REQ-014 SHALL hold an N_CHARS x 8 character buffer with every entry initialised to 0x20 (space); reset SHALL NOT modify it.
REQ-015 SHALL write wr_char to entry wr_addr when wr_en=1; an out-of-range wr_addr SHALL be ignored.
REQ-016 SHALL return the old entry on a same-cycle read and write to one address (read-before-write); the new value SHALL be visible from the next cycle.
REQ-017 SHALL define the box as X0 <= DrawX < X0+8*SCALE*N_CHARS and Y0 <= DrawY < Y0+16*SCALE; outside the box text_on SHALL be 0.
REQ-018 SHALL compute c=(DrawX-X0)/(8*SCALE), fx=((DrawX-X0)/SCALE) mod 8 and fy=(DrawY-Y0)/SCALE using exact division for any SCALE, including non-powers of two.
REQ-019 Stage 1 SHALL register in_box, c, fx and fy and perform a synchronous buffer read of entry c.
REQ-020 Stage 2 SHALL drive an internal font_rom (11-bit address, 8-bit data, combinational) at address char*16+fy and register text_on = in_box & visible(c) & data[7-fx].
REQ-021 SHALL assert frame_tick for exactly one cycle when DrawX=0 and DrawY=0 is sampled, and not again until the coordinate leaves and returns to (0,0).
REQ-022 SHALL run a blink counter on frame_tick in all modes; on reaching BLINK_FRAMES-1 the counter SHALL clear and blink_phase SHALL toggle.
REQ-023 In mode 01, visible(c) SHALL be !blink_phase for all c.
REQ-024 Reveal FSM states: IDLE and REVEAL.
REQ-025 IDLE SHALL hold reveal_cnt=N_CHARS; restart=1 with mode=10 SHALL move to REVEAL with reveal_cnt=0 and the frame sub-counter at 0.
REQ-026 REVEAL SHALL increment reveal_cnt every REVEAL_FRAMES frame_ticks and return to IDLE in the cycle reveal_cnt reaches N_CHARS.
REQ-027 restart during REVEAL SHALL reload reveal_cnt=0; mode leaving 10 during REVEAL SHALL force IDLE next cycle; restart in other modes SHALL be ignored.
REQ-028 In mode 10, visible(c) SHALL be (c < reveal_cnt); in modes 00 and 11 it SHALL be 1.
REQ-029 busy SHALL be 1 exactly while the FSM is in REVEAL (registered).

Reset
REQ-030 reset_n=0 at a clock edge SHALL set text_on=0, busy=0, FSM=IDLE, reveal_cnt=N_CHARS, blink counter=0, blink_phase=0, reveal sub-counter=0, pipeline in_box=0 and frame-tick detector clear.
REQ-031 Reset mid-REVEAL SHALL abort the reveal, and all text SHALL be visible after reset in mode 10.

Verification
REQ-032 With defaults, write 0x50 ('P') at addr 0 and scan DrawY=406 (fy=2, row 0xFC): text_on=1 for DrawX 56..73 and 0 for 74..79, each two cycles after its coordinate.
REQ-033 Edge check: DrawX=55, DrawX=584, DrawY=399 and DrawY=448 SHALL give text_on=0 with non-space buffer contents.
REQ-034 Same-cycle write 0x41 to addr 0 while scanning char 0 SHALL show the old glyph that cycle and 'A' from the next read.
REQ-035 mode=01, BLINK_FRAMES=2: text SHALL be visible for frames 0-1, hidden for frames 2-3 and visible for frames 4-5.
REQ-036 mode=10, REVEAL_FRAMES=1, N_CHARS=4: after restart, busy=1 and characters 0..3 SHALL appear one per frame; busy SHALL drop on the 4th frame_tick, and restart at the 2nd frame SHALL reset reveal_cnt to 0.
REQ-037 reset_n=0 for one cycle mid-REVEAL SHALL give busy=0 and text_on=0 next cycle, with full text visible afterwards.
